// File: rtl/cpu_params_pkg.sv
// RisKy1 core-wide parameters shared by the core and its harness.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_params_pkg;

  // Register (GPR) width of the core
  localparam int RSZ = 32;

endpackage

// File: rtl/tb_ctrl_pkg.sv
// Types and constants for the bench run controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tb_ctrl_pkg;

  typedef enum logic [2:0] {RST_HOLD, RUN, SETTLE, CHECK, FLUSH, DONE} run_state_t;

  // Width of the saturating missed-interrupt counter
  localparam int IRQ_MISS_W = 16;

endpackage

// File: rtl/tb_irq_gen.sv
// Periodic level-sensitive external interrupt source with a missed-tick counter.
// Latency: request visible one cycle after the period tick; ack clears it one cycle later.
// Backpressure: none; a tick that finds the previous request still pending is counted as a miss.
module tb_irq_gen
  import tb_ctrl_pkg::*;
#(
  parameter int IRQ_PERIOD = 0
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  en,
  input  logic                  irq_ack_in,
  output logic                  ext_irq_out,
  output logic [IRQ_MISS_W-1:0] miss_cnt
);

  localparam int PW = (IRQ_PERIOD > 1) ? $clog2(IRQ_PERIOD) : 1;

  generate
    if (IRQ_PERIOD > 0) begin : g_gen
      logic [PW-1:0] period_cnt;
      logic          tick;

      assign tick = en && (period_cnt == PW'(IRQ_PERIOD - 1));

      // Period counter, request level and miss counter; all frozen and the request dropped when disabled
      always_ff @(posedge clk_in) begin
        if (reset_in) begin
          period_cnt  <= '0;
          ext_irq_out <= 1'b0;
          miss_cnt    <= '0;
        end else if (!en) begin
          ext_irq_out <= 1'b0;
        end else begin
          period_cnt <= tick ? '0 : period_cnt + 1'b1;
          // A new tick wins over an ack of the old request in the same cycle
          if (tick) begin
            ext_irq_out <= 1'b1;
          end else if (irq_ack_in) begin
            ext_irq_out <= 1'b0;
          end
          if (tick && ext_irq_out && !irq_ack_in && (miss_cnt != '1)) begin
            miss_cnt <= miss_cnt + 1'b1;
          end
        end
      end
    end else begin : g_off
      logic unused_in;
      assign unused_in   = ^{clk_in, reset_in, en, irq_ack_in};
      assign ext_irq_out = 1'b0;
      assign miss_cnt    = '0;
    end
  endgenerate

endmodule

// File: rtl/tb_run_ctrl.sv
// Bench run controller: core reset sequencing, run-cycle count, stop/result check, watchdog, interrupts.
// Latency: pass/fail two cycles after the stop is sampled, done DRAIN cycles later; done one cycle after a timeout.
// Backpressure: none; stop requests are sampled only in RUN and ignored elsewhere.
module tb_run_ctrl
  import cpu_params_pkg::*;
  import tb_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 50,
  parameter int TIMEOUT    = 1_000_000,
  parameter int CNT_W      = 32,
  parameter int N_STOP     = 1,
  parameter int DRAIN      = 5,
  parameter int IRQ_PERIOD = 0
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic [N_STOP-1:0]       sim_stop_in,
  input  logic [RSZ-1:0]          result_in,
  input  logic [RSZ-1:0]          expect_in,
  input  logic                    irq_ack_in,
  output logic                    core_reset_out,
  output logic                    ext_irq_out,
  output logic [CNT_W-1:0]        clock_cycle_out,
  output logic [$clog2(N_STOP):0] stop_id_out,
  output logic [IRQ_MISS_W-1:0]   irq_miss_out,
  output logic                    pass_out,
  output logic                    fail_out,
  output logic                    timeout_out,
  output logic                    done_out
);

  localparam int SID_W = $clog2(N_STOP) + 1;
  localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int DR_W  = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  run_state_t       state_q, state_d;
  logic [RC_W-1:0]  rst_cnt;
  logic [DR_W-1:0]  drain_cnt;
  logic [SID_W-1:0] stop_lo;
  logic             stop_any;
  logic             timeout_hit;
  logic             run_stay;

  assign stop_any    = |sim_stop_in;
  assign timeout_hit = (clock_cycle_out == CNT_W'(TIMEOUT - 1));
  // Counters and the interrupt source only advance on cycles that stay in RUN,
  // so the stop/timeout cycle itself freezes them
  assign run_stay    = (state_q == RUN) && (state_d == RUN);

  // Priority encode the lowest asserted stop channel
  always_comb begin
    stop_lo = '1;
    for (int i = N_STOP - 1; i >= 0; i--) begin
      if (sim_stop_in[i]) stop_lo = SID_W'(i);
    end
  end

  // Next-state decode; a stop beats a simultaneous timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RST_HOLD: if ((RST_CYCLES == 0) || (rst_cnt == '0)) state_d = RUN;
      RUN: begin
        if (stop_any)         state_d = SETTLE;
        else if (timeout_hit) state_d = DONE;
      end
      SETTLE:   state_d = CHECK;
      CHECK:    state_d = (DRAIN == 0) ? DONE : FLUSH;
      FLUSH:    if (drain_cnt == '0) state_d = DONE;
      DONE:     state_d = DONE;
      default:  state_d = RST_HOLD;
    endcase
  end

  // State register plus reset-hold and drain down-counters
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= RST_HOLD;
      rst_cnt   <= RC_W'(RST_CYCLES - 1);
      drain_cnt <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == RST_HOLD) && (rst_cnt != '0)) rst_cnt <= rst_cnt - 1'b1;
      if ((state_d == FLUSH) && (state_q != FLUSH)) begin
        drain_cnt <= DR_W'(DRAIN - 1);
      end else if (state_q == FLUSH) begin
        drain_cnt <= drain_cnt - 1'b1;
      end
    end
  end

  // Registered outputs; verdict flags are sticky until reset
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      core_reset_out  <= 1'b1;
      clock_cycle_out <= '0;
      stop_id_out     <= '1;
      pass_out        <= 1'b0;
      fail_out        <= 1'b0;
      timeout_out     <= 1'b0;
      done_out        <= 1'b0;
    end else begin
      core_reset_out <= (state_d == RST_HOLD);
      if (run_stay && (clock_cycle_out != '1)) clock_cycle_out <= clock_cycle_out + 1'b1;
      if ((state_q == RUN) && stop_any) stop_id_out <= stop_lo;
      if ((state_q == RUN) && (state_d == DONE)) begin
        timeout_out <= 1'b1;
        fail_out    <= 1'b1;
      end
      // An unknown result makes the equality non-true and lands on fail
      if (state_q == CHECK) begin
        if (result_in == expect_in) pass_out <= 1'b1;
        else                        fail_out <= 1'b1;
      end
      // Timeout skips the drain; done then trails the timeout flag by one cycle
      done_out <= (state_d == DONE) && (state_q != RUN);
    end
  end

  tb_irq_gen #(
    .IRQ_PERIOD(IRQ_PERIOD)
  ) u_irq_gen (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .en         (run_stay),
    .irq_ack_in (irq_ack_in),
    .ext_irq_out(ext_irq_out),
    .miss_cnt   (irq_miss_out)
  );

endmodule

// File: tb/tb_tb_run_ctrl.sv
// Directed bench for the run controller: reset release, pass/fail paths, stop priority,
// interrupt generator, mid-run reset, and watchdog timeout on a second instance.
module tb_tb_run_ctrl;
  import cpu_params_pkg::*;

  logic clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  logic           rst, rst_to, ack;
  logic [3:0]     stop;
  logic           stop_to;
  logic [RSZ-1:0] result, exp_val;

  logic        core_rst, ext_irq, pass, fail, tmo, done;
  logic [31:0] cyc;
  logic [2:0]  stop_id;
  logic [15:0] miss;

  logic        to_core_rst, to_ext_irq, to_pass, to_fail, to_tmo, to_done;
  logic [31:0] to_cyc;
  logic [0:0]  to_stop_id;
  logic [15:0] to_miss;

  int n_checks = 0;
  int n_errors = 0;

  tb_run_ctrl #(
    .RST_CYCLES(4), .TIMEOUT(1000), .CNT_W(32), .N_STOP(4), .DRAIN(5), .IRQ_PERIOD(8)
  ) u_main (
    .clk_in(clk_100), .reset_in(rst), .sim_stop_in(stop), .result_in(result),
    .expect_in(exp_val), .irq_ack_in(ack), .core_reset_out(core_rst), .ext_irq_out(ext_irq),
    .clock_cycle_out(cyc), .stop_id_out(stop_id), .irq_miss_out(miss), .pass_out(pass),
    .fail_out(fail), .timeout_out(tmo), .done_out(done)
  );

  tb_run_ctrl #(
    .RST_CYCLES(4), .TIMEOUT(20), .CNT_W(32), .N_STOP(1), .DRAIN(5), .IRQ_PERIOD(0)
  ) u_to (
    .clk_in(clk_100), .reset_in(rst_to), .sim_stop_in(stop_to), .result_in(result),
    .expect_in(exp_val), .irq_ack_in(1'b0), .core_reset_out(to_core_rst), .ext_irq_out(to_ext_irq),
    .clock_cycle_out(to_cyc), .stop_id_out(to_stop_id), .irq_miss_out(to_miss), .pass_out(to_pass),
    .fail_out(to_fail), .timeout_out(to_tmo), .done_out(to_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_100);
      #1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_core_rst"}, core_rst, 1);
    check({tag, "_cyc"},      cyc,      0);
    check({tag, "_stop_id"},  stop_id,  7);
    check({tag, "_miss"},     miss,     0);
    check({tag, "_irq"},      ext_irq,  0);
    check({tag, "_pass"},     pass,     0);
    check({tag, "_fail"},     fail,     0);
    check({tag, "_tmo"},      tmo,      0);
    check({tag, "_done"},     done,     0);
  endtask

  // Reset, release, and walk through the 4-cycle hold into the first RUN cycle
  task automatic start_run();
    rst  = 1'b1;
    stop = 4'b0000;
    ack  = 1'b0;
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("rst_hold", core_rst, 1);
    end
    step(1);
    check("rst_release", core_rst, 0);
    check("run_cyc0", cyc, 0);
  endtask

  // Pulse a stop at the current RUN cycle and follow the verdict and drain timing
  task automatic stop_and_check(input logic [3:0] s, input logic [RSZ-1:0] r,
                                input logic exp_pass, input logic [2:0] exp_id, input int exp_cyc);
    stop   = s;
    result = r;
    step(1);
    stop = 4'b0000;
    check("stop_cyc_frozen", cyc, exp_cyc);
    check("stop_irq_off", ext_irq, 0);
    step(1);
    check("settle_no_pass", pass, 0);
    check("settle_no_fail", fail, 0);
    step(1);
    check("verdict_pass", pass, exp_pass);
    check("verdict_fail", fail, !exp_pass);
    check("stop_id", stop_id, exp_id);
    check("verdict_not_done", done, 0);
    step(4);
    check("drain_not_done", done, 0);
    step(1);
    check("done_rise", done, 1);
    check("done_cyc_frozen", cyc, exp_cyc);
    check("done_no_tmo", tmo, 0);
  endtask

  initial begin
    rst     = 1'b1;
    rst_to  = 1'b1;
    stop    = 4'b0000;
    stop_to = 1'b0;
    ack     = 1'b0;
    result  = '0;
    exp_val = 1;
    step(3);
    check_reset_vals("reset");

    // Run 1: acked interrupts, then a pass at cycle 100
    start_run();
    for (int c = 1; c <= 100; c++) begin
      step(1);
      if (c == 2)  check("cyc2", cyc, 2);
      if (c == 7)  check("irq_c7", ext_irq, 0);
      if (c == 8)  check("irq_c8", ext_irq, 1);
      if (c == 11) check("irq_c11_acked", ext_irq, 0);
      if (c == 16) check("irq_c16", ext_irq, 1);
      if (c == 19) check("irq_c19_acked", ext_irq, 0);
      if (c == 20) check("miss_c20", miss, 0);
      ack = (c == 10) || (c == 18);
    end
    check("cyc100", cyc, 100);
    check("miss_c100", miss, 9);
    stop_and_check(4'b0001, 1, 1'b1, 3'd0, 100);
    check("miss_frozen", miss, 9);

    // Run 2: never ack, then reset in the middle of RUN
    start_run();
    for (int c = 1; c <= 50; c++) begin
      step(1);
      if (c == 31) check("miss_c31", miss, 2);
      if (c == 32) check("miss_c32", miss, 3);
    end
    check("miss_c50", miss, 5);
    check("irq_c50_pending", ext_irq, 1);
    check("cyc50", cyc, 50);
    rst = 1'b1;
    step(1);
    check_reset_vals("midrun_rst");

    // Run 3: fresh run after the mid-run reset passes normally
    start_run();
    step(10);
    stop_and_check(4'b0100, 1, 1'b1, 3'd2, 10);

    // Run 4: several stop bits, wrong result
    start_run();
    step(5);
    stop_and_check(4'b1010, 0, 1'b0, 3'd1, 5);

    // Watchdog: TIMEOUT=20, no stop
    rst_to = 1'b0;
    step(3);
    check("to_hold", to_core_rst, 1);
    step(1);
    check("to_release", to_core_rst, 0);
    step(19);
    check("to_cyc19", to_cyc, 19);
    check("to_not_yet", to_tmo, 0);
    step(1);
    check("to_tmo", to_tmo, 1);
    check("to_fail", to_fail, 1);
    check("to_pass", to_pass, 0);
    check("to_cyc_frozen", to_cyc, 19);
    check("to_stop_id", to_stop_id, 1);
    check("to_done_late", to_done, 0);
    step(1);
    check("to_done", to_done, 1);
    step(3);
    check("to_cyc_hold", to_cyc, 19);
    check("to_done_hold", to_done, 1);
    check("to_irq", to_ext_irq, 0);
    check("to_miss", to_miss, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
